vga_box_renderer: RTL and testbench
===================================

# vga_box_renderer

Pixel-generation stage that sits directly downstream of `VGA_timings`. It consumes the horizontal/vertical pixel counters and sync pulses and produces 12-bit RGB for a solid square box that moves diagonally and bounces off the screen edges. The box colour cycles on every bounce. The block also re-times the sync pulses so that they stay aligned with its registered colour outputs.

## Interface
Parameters:
- `WIDTH`, 640: visible pixels per line.
- `HEIGHT`, 480: visible lines per frame.
- `BOX_SIZE`, 32: box edge length in pixels. Must be less than `HEIGHT`.
- `STEP`, 1: pixels moved per axis per frame. Must be at least 1 and less than `HEIGHT - BOX_SIZE`.
- `BG_COLOR`, 12'h000: background RGB (4:4:4).

Ports (one clock; reset is synchronous and active-high):
- `iClk`, input, 1: pixel clock, shared with `VGA_timings`.
- `iRst`, input, 1: synchronous, active-high reset.
- `iCountH`, input, 10: horizontal counter from `VGA_timings`.
- `iCountV`, input, 10: vertical counter from `VGA_timings`.
- `iHS`, input, 1: horizontal sync from `VGA_timings`. Polarity is passed through unchanged.
- `iVS`, input, 1: vertical sync from `VGA_timings`. Polarity is passed through unchanged.
- `oRed`, output, 4: red channel.
- `oGreen`, output, 4: green channel.
- `oBlue`, output, 4: blue channel.
- `oHS`, output, 1: `iHS` delayed by one clock.
- `oVS`, output, 1: `iVS` delayed by one clock.
- `oFrameTick`, output, 1: one-cycle pulse, registered, asserted the cycle after a position update.

## Operation
- Visible region: `iCountH < WIDTH` and `iCountV < HEIGHT`.
- Box region: the visible region, plus `posX <= iCountH < posX+BOX_SIZE` and `posY <= iCountV < posY+BOX_SIZE`.
- Colour output:
  - box region: `palette[colIdx]`;
  - visible region outside the box: `BG_COLOR`;
  - outside the visible region: 12'h000 (blanking is mandatory).
- Palette by `colIdx`: 0 = 12'hF00, 1 = 12'h0F0, 2 = 12'h00F, 3 = 12'hFF0.
- Frame tick condition: `iCountH == 0` and `iCountV == HEIGHT`. This is the first pixel of the first blanking line and occurs once per frame. Position, direction and colour registers update only on this cycle, so there is no tearing.
- Per-axis direction state machine, states INC/DEC (X shown; Y is identical with `HEIGHT`):
  - INC, if `posX + BOX_SIZE + STEP > WIDTH`: `posX` becomes `WIDTH - BOX_SIZE`, state becomes DEC, bounce is flagged.
  - INC, otherwise: `posX` becomes `posX + STEP`.
  - DEC, if `posX < STEP`: `posX` becomes 0, state becomes INC, bounce is flagged.
  - DEC, otherwise: `posX` becomes `posX - STEP`.
- Colour index: `colIdx` increments by 1 (mod 4) on a tick where either axis bounces. A simultaneous X and Y bounce (corner hit) increments it once only.
- Arithmetic: compare in 11 bits so that `posX + BOX_SIZE + STEP` cannot wrap. `posX` and `posY` are 10-bit.
- Counter values outside the legal range (`iCountH` at or above the line total) are treated as blanking. No error is flagged.

## Timing
- Latency: colour for input counts (H,V) appears on `oRed/oGreen/oBlue` one clock later. `oHS` and `oVS` carry the same one-clock delay, so RGB and sync stay aligned.
- Position registers update at the clock edge that samples the tick condition. The new position affects pixels from the next cycle onward, which are all in blanking.
- `oFrameTick` is high for exactly one cycle, one clock after the tick condition is sampled.
- Reset values (at the first edge with `iRst` = 1):
  - `oRed`, `oGreen`, `oBlue`: 0.
  - `oHS`, `oVS`: 0.
  - `oFrameTick`: 0.
  - `posX`, `posY`: 0.
  - Both axes: INC.
  - `colIdx`: 0.
- Reset mid-frame: all state returns to reset values at that edge. Normal rendering resumes on the first edge with `iRst` = 0, with no requirement to wait for the frame start.
- A tick condition sampled while `iRst` = 1 is ignored: no movement and no `oFrameTick`.

## Test plan
- Reset: hold `iRst` high for 3 clocks while driving H=5, V=5. All outputs read 0 after the first edge. `posX` = `posY` = 0.
- Box render (defaults, after reset):
  - drive H=31, V=0: next clock RGB = 12'hF00;
  - drive H=32, V=0: RGB = 12'h000 (`BG_COLOR`);
  - drive H=700, V=10: RGB = 12'h000;
  - `oHS`/`oVS` equal the previous cycle's `iHS`/`iVS`.
- Movement: drive one tick (H=0, V=480).
  - `oFrameTick` pulses once, one cycle later.
  - Then H=0, V=0 gives background; H=1, V=1 gives 12'hF00 (box now at 1,1).
- Right-edge bounce, `STEP`=2: force X to 606 in INC.
  - Tick 1: X becomes 608.
  - Tick 2: X stays 608, state becomes DEC, `colIdx` becomes 1, box renders 12'h0F0.
  - Tick 3: X becomes 606.
- Corner bounce: place the box at X=608, Y=448, both INC, then apply one tick. Both axes become DEC and `colIdx` increments once (0 to 1, not 2).
- Reset mid-frame: after 10 ticks (X=Y=10), assert `iRst` for one clock during visible line 200. RGB is 0 the next cycle. Afterwards, H=0, V=0 renders 12'hF00 (position back at 0,0, `colIdx` 0).

Source files
------------

// File: rtl/vga_box_renderer.sv
// Colour stage behind VGA_timings: draws a bouncing square box and re-times the sync pulses.
// All outputs are registered, so RGB and sync lag the input counters by exactly one clock.
module vga_box_renderer #(
    parameter int          WIDTH    = 640,
    parameter int          HEIGHT   = 480,
    parameter int          BOX_SIZE = 32,
    parameter int          STEP     = 1,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [9:0] iCountH,
    input  logic [9:0] iCountV,
    input  logic       iHS,
    input  logic       iVS,
    output logic [3:0] oRed,
    output logic [3:0] oGreen,
    output logic [3:0] oBlue,
    output logic       oHS,
    output logic       oVS,
    output logic       oFrameTick,
    output logic [9:0] dbg_pos_x,
    output logic [9:0] dbg_pos_y,
    output logic       dbg_dir_x,
    output logic       dbg_dir_y,
    output logic [1:0] dbg_col_idx
);

    typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_t;

    localparam logic [10:0] W11    = 11'(WIDTH);
    localparam logic [10:0] H11    = 11'(HEIGHT);
    localparam logic [10:0] BOX11  = 11'(BOX_SIZE);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [9:0]  STEP10 = 10'(STEP);
    localparam logic [9:0]  X_MAX  = 10'(WIDTH - BOX_SIZE);
    localparam logic [9:0]  Y_MAX  = 10'(HEIGHT - BOX_SIZE);

    logic [9:0]  pos_x, pos_y, pos_x_nxt, pos_y_nxt;
    dir_t        dir_x, dir_y, dir_x_nxt, dir_y_nxt;
    logic [1:0]  col_idx;
    logic        bounce_x, bounce_y;
    logic        tick, visible, in_box;
    logic [11:0] palette_col, color_nxt;

    // First pixel of the first blanking line; the only cycle where motion state changes.
    assign tick = (iCountH == 10'd0) && ({1'b0, iCountV} == H11);

    always_comb begin
        pos_x_nxt = pos_x;
        dir_x_nxt = dir_x;
        bounce_x  = 1'b0;
        case (dir_x)
            DIR_INC: begin
                if ({1'b0, pos_x} + BOX11 + STEP11 > W11) begin
                    pos_x_nxt = X_MAX;
                    dir_x_nxt = DIR_DEC;
                    bounce_x  = 1'b1;
                end else begin
                    pos_x_nxt = pos_x + STEP10;
                end
            end
            DIR_DEC: begin
                if ({1'b0, pos_x} < STEP11) begin
                    pos_x_nxt = 10'd0;
                    dir_x_nxt = DIR_INC;
                    bounce_x  = 1'b1;
                end else begin
                    pos_x_nxt = pos_x - STEP10;
                end
            end
            default: dir_x_nxt = DIR_INC;
        endcase
    end

    always_comb begin
        pos_y_nxt = pos_y;
        dir_y_nxt = dir_y;
        bounce_y  = 1'b0;
        case (dir_y)
            DIR_INC: begin
                if ({1'b0, pos_y} + BOX11 + STEP11 > H11) begin
                    pos_y_nxt = Y_MAX;
                    dir_y_nxt = DIR_DEC;
                    bounce_y  = 1'b1;
                end else begin
                    pos_y_nxt = pos_y + STEP10;
                end
            end
            DIR_DEC: begin
                if ({1'b0, pos_y} < STEP11) begin
                    pos_y_nxt = 10'd0;
                    dir_y_nxt = DIR_INC;
                    bounce_y  = 1'b1;
                end else begin
                    pos_y_nxt = pos_y - STEP10;
                end
            end
            default: dir_y_nxt = DIR_INC;
        endcase
    end

    // 11-bit compares keep pos + BOX_SIZE from wrapping near the right/bottom edge.
    assign visible = ({1'b0, iCountH} < W11) && ({1'b0, iCountV} < H11);
    assign in_box  = ({1'b0, iCountH} >= {1'b0, pos_x}) && ({1'b0, iCountH} < {1'b0, pos_x} + BOX11) &&
                     ({1'b0, iCountV} >= {1'b0, pos_y}) && ({1'b0, iCountV} < {1'b0, pos_y} + BOX11);

    always_comb begin
        palette_col = 12'hF00;
        case (col_idx)
            2'd0: palette_col = 12'hF00;
            2'd1: palette_col = 12'h0F0;
            2'd2: palette_col = 12'h00F;
            2'd3: palette_col = 12'hFF0;
            default: palette_col = 12'hF00;
        endcase
        color_nxt = 12'h000;
        if (visible) color_nxt = in_box ? palette_col : BG_COLOR;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            {oRed, oGreen, oBlue} <= 12'h000;
            oHS        <= 1'b0;
            oVS        <= 1'b0;
            oFrameTick <= 1'b0;
            pos_x      <= 10'd0;
            pos_y      <= 10'd0;
            dir_x      <= DIR_INC;
            dir_y      <= DIR_INC;
            col_idx    <= 2'd0;
        end else begin
            {oRed, oGreen, oBlue} <= color_nxt;
            oHS        <= iHS;
            oVS        <= iVS;
            oFrameTick <= tick;
            if (tick) begin
                pos_x <= pos_x_nxt;
                pos_y <= pos_y_nxt;
                dir_x <= dir_x_nxt;
                dir_y <= dir_y_nxt;
                // A corner hit bounces both axes but advances the colour only once.
                if (bounce_x || bounce_y) col_idx <= col_idx + 2'd1;
            end
        end
    end

    assign dbg_pos_x   = pos_x;
    assign dbg_pos_y   = pos_y;
    assign dbg_dir_x   = dir_x;
    assign dbg_dir_y   = dir_y;
    assign dbg_col_idx = col_idx;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Bench for vga_box_renderer: three parameterisations driven in lockstep against a
// behavioural model of box position, bounce and colour.
module tb_vga_box_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] cnt_h, cnt_v;
    logic       hs_in, vs_in;

    logic [3:0] red [3];
    logic [3:0] green [3];
    logic [3:0] blue [3];
    logic       hs_out [3];
    logic       vs_out [3];
    logic       frame_tick [3];
    logic [9:0] pos_x [3];
    logic [9:0] pos_y [3];
    logic       dir_x [3];
    logic       dir_y [3];
    logic [1:0] col_idx [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: STEP=2. Instance 2: square screen for corner hits.
    vga_box_renderer dut0 (
        .iClk(clk), .iRst(rst), .iCountH(cnt_h), .iCountV(cnt_v), .iHS(hs_in), .iVS(vs_in),
        .oRed(red[0]), .oGreen(green[0]), .oBlue(blue[0]), .oHS(hs_out[0]), .oVS(vs_out[0]),
        .oFrameTick(frame_tick[0]), .dbg_pos_x(pos_x[0]), .dbg_pos_y(pos_y[0]),
        .dbg_dir_x(dir_x[0]), .dbg_dir_y(dir_y[0]), .dbg_col_idx(col_idx[0])
    );

    vga_box_renderer #(.STEP(2)) dut1 (
        .iClk(clk), .iRst(rst), .iCountH(cnt_h), .iCountV(cnt_v), .iHS(hs_in), .iVS(vs_in),
        .oRed(red[1]), .oGreen(green[1]), .oBlue(blue[1]), .oHS(hs_out[1]), .oVS(vs_out[1]),
        .oFrameTick(frame_tick[1]), .dbg_pos_x(pos_x[1]), .dbg_pos_y(pos_y[1]),
        .dbg_dir_x(dir_x[1]), .dbg_dir_y(dir_y[1]), .dbg_col_idx(col_idx[1])
    );

    vga_box_renderer #(.WIDTH(480), .HEIGHT(480)) dut2 (
        .iClk(clk), .iRst(rst), .iCountH(cnt_h), .iCountV(cnt_v), .iHS(hs_in), .iVS(vs_in),
        .oRed(red[2]), .oGreen(green[2]), .oBlue(blue[2]), .oHS(hs_out[2]), .oVS(vs_out[2]),
        .oFrameTick(frame_tick[2]), .dbg_pos_x(pos_x[2]), .dbg_pos_y(pos_y[2]),
        .dbg_dir_x(dir_x[2]), .dbg_dir_y(dir_y[2]), .dbg_col_idx(col_idx[2])
    );

    // Reference model: screen geometry per instance plus box state (dir 0 = moving up-count).
    localparam int BOX = 32;
    int p_w [3]    = '{640, 640, 480};
    int p_h [3]    = '{480, 480, 480};
    int p_step [3] = '{1, 2, 1};
    int m_x [3], m_y [3], m_dx [3], m_dy [3], m_col [3];

    function automatic logic [11:0] palette(int c);
        case (c % 4)
            0: return 12'hF00;
            1: return 12'h0F0;
            2: return 12'h00F;
            default: return 12'hFF0;
        endcase
    endfunction

    function automatic logic [11:0] model_rgb(int k, int hh, int vv);
        if (hh >= p_w[k] || vv >= p_h[k]) return 12'h000;
        if (hh >= m_x[k] && hh < m_x[k] + BOX && vv >= m_y[k] && vv < m_y[k] + BOX)
            return palette(m_col[k]);
        return 12'h000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_x[k] = 0; m_y[k] = 0; m_dx[k] = 0; m_dy[k] = 0; m_col[k] = 0;
        end
    endtask

    // One frame of motion: a box that would cross an edge is parked against it and turns round.
    task automatic model_move(int k);
        bit hit = 0;
        int lim_x = p_w[k] - BOX;
        int lim_y = p_h[k] - BOX;
        int s = p_step[k];
        if (m_dx[k] == 0) begin
            if (m_x[k] + s > lim_x) begin m_x[k] = lim_x; m_dx[k] = 1; hit = 1; end
            else m_x[k] = m_x[k] + s;
        end else begin
            if (m_x[k] - s < 0) begin m_x[k] = 0; m_dx[k] = 0; hit = 1; end
            else m_x[k] = m_x[k] - s;
        end
        if (m_dy[k] == 0) begin
            if (m_y[k] + s > lim_y) begin m_y[k] = lim_y; m_dy[k] = 1; hit = 1; end
            else m_y[k] = m_y[k] + s;
        end else begin
            if (m_y[k] - s < 0) begin m_y[k] = 0; m_dy[k] = 0; hit = 1; end
            else m_y[k] = m_y[k] - s;
        end
        if (hit) m_col[k] = (m_col[k] + 1) % 4;
    endtask

    task automatic check(string tag, int k, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", tag, k, $time, got, exp);
        end
    endtask

    // Called at a falling edge: drive one pixel, predict, advance past the next rising edge, compare.
    task automatic apply(int hh, int vv, bit hsi, bit vsi, bit rsti);
        logic [11:0] e_rgb [3];
        bit e_tick [3];
        cnt_h = 10'(hh); cnt_v = 10'(vv); hs_in = hsi; vs_in = vsi; rst = rsti;
        for (int k = 0; k < 3; k++) begin
            e_rgb[k]  = rsti ? 12'h000 : model_rgb(k, hh, vv);
            e_tick[k] = !rsti && hh == 0 && vv == p_h[k];
        end
        if (rsti) model_reset();
        else for (int k = 0; k < 3; k++) if (e_tick[k]) model_move(k);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rgb", k, {20'd0, red[k], green[k], blue[k]}, {20'd0, e_rgb[k]});
            check("hs", k, {31'd0, hs_out[k]}, {31'd0, hsi & ~rsti});
            check("vs", k, {31'd0, vs_out[k]}, {31'd0, vsi & ~rsti});
            check("frame_tick", k, {31'd0, frame_tick[k]}, {31'd0, e_tick[k]});
            check("pos_x", k, {22'd0, pos_x[k]}, 32'(m_x[k]));
            check("pos_y", k, {22'd0, pos_y[k]}, 32'(m_y[k]));
            check("dir_x", k, {31'd0, dir_x[k]}, 32'(m_dx[k]));
            check("dir_y", k, {31'd0, dir_y[k]}, 32'(m_dy[k]));
            check("col_idx", k, {30'd0, col_idx[k]}, 32'(m_col[k]));
        end
    endtask

    task automatic frame_tick_in();
        apply(0, 480, $urandom_range(0, 1), $urandom_range(0, 1), 0);
    endtask

    initial begin
        rst = 1'b1; cnt_h = 10'd5; cnt_v = 10'd5; hs_in = 1'b1; vs_in = 1'b1;
        model_reset();
        @(negedge clk);

        repeat (3) apply(5, 5, 1, 1, 1);

        apply(31, 0, 0, 1, 0);
        apply(32, 0, 1, 0, 0);
        apply(700, 10, 1, 1, 0);
        check("rgb_box_edge_default", 0, {20'd0, red[0], green[0], blue[0]}, 32'h000);

        frame_tick_in();
        apply(0, 0, 0, 0, 0);
        apply(1, 1, 1, 1, 0);
        check("rgb_after_move", 0, {20'd0, red[0], green[0], blue[0]}, 32'hF00);

        // Random pixels, biased toward the box neighbourhood, with frame ticks mixed in.
        repeat (1500) begin
            int sel = $urandom_range(0, 7);
            if (sel < 2) frame_tick_in();
            else if (sel < 5) apply(m_x[0] + $urandom_range(0, 33) - 1 < 0 ? 0 : m_x[0] + $urandom_range(0, 33) - 1,
                                    m_y[0] + $urandom_range(0, 33) - 1 < 0 ? 0 : m_y[0] + $urandom_range(0, 33) - 1,
                                    $urandom_range(0, 1), $urandom_range(0, 1), 0);
            else apply($urandom_range(0, 1023), $urandom_range(0, 1023),
                       $urandom_range(0, 1), $urandom_range(0, 1), 0);
        end

        // Right-edge bounce on the STEP=2 instance.
        apply(0, 0, 0, 0, 1);
        for (int i = 0; i < 400 && m_x[1] != 606; i++) frame_tick_in();
        check("reach_606", 1, {22'd0, pos_x[1]}, 32'd606);
        repeat (3) begin
            frame_tick_in();
            apply(m_x[1], m_y[1], 0, 0, 0);
            apply(m_x[1] + 31, m_y[1] + 31, 0, 0, 0);
            apply(m_x[1] + 32, m_y[1], 0, 0, 0);
        end

        // Corner hit on the square-screen instance: both axes turn, colour advances once.
        apply(0, 0, 0, 0, 1);
        repeat (449) frame_tick_in();
        check("corner_col", 2, {30'd0, col_idx[2]}, 32'd1);
        apply(448, 448, 0, 0, 0);

        // Reset during visible line 200 after ten frames.
        apply(0, 0, 0, 0, 1);
        repeat (10) frame_tick_in();
        apply(100, 200, 1, 1, 1);
        apply(0, 0, 0, 0, 0);
        check("rgb_after_midreset", 0, {20'd0, red[0], green[0], blue[0]}, 32'hF00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
